color_frame_tx: RTL

//  Multi-channel successor of the single-LED colour transmitter. On a tx request it

---
 rtl/color_frame_tx_if.sv | 38 +++
 rtl/color_frame_tx.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/color_frame_tx_if.sv
// ---------------------------------------------------------------------------
// color_frame_tx_if
//   Symbol stream between the colour frame transmitter and the downstream
//   link/serializer. A symbol transfers on any rising clock edge where
//   col_valid && col_ready.
//
//   col        2-bit colour code (BLANCO=0, ROJO=1, VERDE=2, AZUL=3)
//   col_valid  col/col_idx hold a valid symbol
//   col_ready  downstream can accept the symbol this cycle
//   col_idx    channel index of the symbol on col
//
//   master : the transmitter (drives col, col_valid, col_idx)
//   slave  : the downstream consumer (drives col_ready)
// ---------------------------------------------------------------------------
interface color_frame_tx_if #(
  parameter int N_CH = 4
);
  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [1:0]       col;
  logic             col_valid;
  logic             col_ready;
  logic [IDX_W-1:0] col_idx;

  modport master (
    output col,
    output col_valid,
    output col_idx,
    input  col_ready
  );

  modport slave (
    input  col,
    input  col_valid,
    input  col_idx,
    output col_ready
  );
endinterface

// File: rtl/color_frame_tx.sv
// ---------------------------------------------------------------------------
// color_frame_tx
//   Multi-channel LED colour transmitter. On a frame request it snapshots
//   N_CH 3-bit LED patterns, decodes each one to a 2-bit colour code and
//   streams the codes, channel 0 first, over a valid/ready handshake.
//
//   Pattern decode (bit2 red, bit1 green, bit0 blue):
//     111 -> BLANCO, 100 -> ROJO, 010 -> VERDE, 001 -> AZUL
//     anything else is invalid: flagged in err_mask and replaced by the
//     channel's last valid code (INV_POLICY=0) or BLANCO (INV_POLICY=1).
//
// Parameters
//   N_CH        number of LED channels per frame (>= 1)
//   INV_POLICY  0 = reuse last valid code, 1 = force BLANCO on invalid
//
// Ports
//   p_clock     system clock, rising edge
//   reset       asynchronous, active-high reset
//   tx          frame request, level-sampled every cycle
//   led_bus     channel i = led_bus[3i+2:3i]
//   col_if      symbol stream (master side): col, col_valid, col_idx out,
//               col_ready in
//   busy        frame in progress
//   frame_done  one-cycle pulse after the last symbol is accepted
//   err_mask    bit i = channel i was invalid in the current/last frame
//   tx_drop     one-cycle pulse: tx seen while a frame was in progress
//
// Every output is a flop; there is no combinational input-to-output path.
// ---------------------------------------------------------------------------
module color_frame_tx #(
  parameter int N_CH       = 4,
  parameter int INV_POLICY = 0
) (
  input  logic              p_clock,
  input  logic              reset,
  input  logic              tx,
  input  logic [3*N_CH-1:0] led_bus,
  color_frame_tx_if.master  col_if,
  output logic              busy,
  output logic              frame_done,
  output logic [N_CH-1:0]   err_mask,
  output logic              tx_drop
);

  localparam int               IDX_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);

  localparam logic [1:0] BLANCO = 2'd0;
  localparam logic [1:0] ROJO   = 2'd1;
  localparam logic [1:0] VERDE  = 2'd2;
  localparam logic [1:0] AZUL   = 2'd3;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  // Decode one LED pattern. Result is {valid, code}; code is BLANCO when
  // the pattern is not one of the four legal encodings.
  function automatic logic [2:0] decode_led(input logic [2:0] pat);
    logic [2:0] res;
    case (pat)
      3'b111:  res = {1'b1, BLANCO};
      3'b100:  res = {1'b1, ROJO};
      3'b010:  res = {1'b1, VERDE};
      3'b001:  res = {1'b1, AZUL};
      default: res = {1'b0, BLANCO};
    endcase
    return res;
  endfunction

  // ---------------------------------------------------------------------
  // State and registers
  // ---------------------------------------------------------------------
  state_t                 state_r;
  state_t                 state_s;

  logic [N_CH-1:0][1:0]   code_r;       // snapshot of decoded codes
  logic [N_CH-1:0][1:0]   code_s;
  logic [N_CH-1:0][1:0]   mem_r;        // last valid code per channel
  logic [N_CH-1:0][1:0]   mem_s;

  logic [1:0]             col_r;
  logic [1:0]             col_s;
  logic                   col_valid_r;
  logic                   col_valid_s;
  logic [IDX_W-1:0]       col_idx_r;
  logic [IDX_W-1:0]       col_idx_s;
  logic                   busy_r;
  logic                   busy_s;
  logic                   frame_done_r;
  logic                   frame_done_s;
  logic [N_CH-1:0]        err_mask_r;
  logic [N_CH-1:0]        err_mask_s;
  logic                   tx_drop_r;
  logic                   tx_drop_s;

  // Decode results for the current led_bus, only consumed on a snapshot.
  logic [N_CH-1:0][2:0]   dec_s;
  logic [N_CH-1:0][1:0]   dec_code_s;
  logic [N_CH-1:0]        dec_valid_s;
  logic [N_CH-1:0][1:0]   mem_upd_s;

  logic                   hs_s;         // symbol accepted this cycle
  logic [IDX_W-1:0]       next_idx_s;

  assign hs_s       = col_valid_r && col_if.col_ready;
  assign next_idx_s = col_idx_r + IDX_W'(1);

  // Per-channel decode of the live LED bus with the invalid-pattern policy.
  // Invalid channels never touch the memory, so the memory always holds the
  // last legal code seen on that channel (BLANCO after reset).
  always_comb begin
    dec_s       = '0;
    dec_code_s  = '0;
    dec_valid_s = '0;
    mem_upd_s   = mem_r;
    for (int i = 0; i < N_CH; i++) begin
      dec_s[i] = decode_led(led_bus[3*i +: 3]);
      if (dec_s[i][2]) begin
        dec_code_s[i]  = dec_s[i][1:0];
        dec_valid_s[i] = 1'b1;
        mem_upd_s[i]   = dec_s[i][1:0];
      end else begin
        if (INV_POLICY == 1) begin
          dec_code_s[i] = BLANCO;
        end else begin
          dec_code_s[i] = mem_r[i];
        end
      end
    end
  end

  // Next-state and next-output logic for the IDLE/SEND frame controller.
  always_comb begin
    state_s      = state_r;
    code_s       = code_r;
    mem_s        = mem_r;
    col_s        = col_r;
    col_valid_s  = col_valid_r;
    col_idx_s    = col_idx_r;
    busy_s       = busy_r;
    err_mask_s   = err_mask_r;
    frame_done_s = 1'b0;
    tx_drop_s    = 1'b0;

    case (state_r)
      S_IDLE: begin
        col_s       = BLANCO;
        col_valid_s = 1'b0;
        col_idx_s   = '0;
        busy_s      = 1'b0;
        if (tx) begin
          // Snapshot: channel 0 is presented on the very next cycle.
          state_s     = S_SEND;
          code_s      = dec_code_s;
          mem_s       = mem_upd_s;
          err_mask_s  = ~dec_valid_s;
          col_s       = dec_code_s[0];
          col_valid_s = 1'b1;
          col_idx_s   = '0;
          busy_s      = 1'b1;
        end else begin
          state_s = S_IDLE;
        end
      end

      S_SEND: begin
        // A request during a frame is ignored but reported.
        tx_drop_s = tx;
        if (hs_s) begin
          if (col_idx_r == LAST_IDX) begin
            state_s      = S_IDLE;
            col_s        = BLANCO;
            col_valid_s  = 1'b0;
            col_idx_s    = '0;
            busy_s       = 1'b0;
            frame_done_s = 1'b1;
          end else begin
            col_idx_s = next_idx_s;
            col_s     = code_r[next_idx_s];
          end
        end else begin
          // Back-pressure: hold the current symbol unchanged.
          state_s = S_SEND;
        end
      end

      default: begin
        state_s     = S_IDLE;
        col_s       = BLANCO;
        col_valid_s = 1'b0;
        col_idx_s   = '0;
        busy_s      = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge p_clock or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Snapshot, channel memory and output registers.
  always_ff @(posedge p_clock or posedge reset) begin
    if (reset) begin
      code_r       <= '0;
      mem_r        <= '0;
      col_r        <= BLANCO;
      col_valid_r  <= 1'b0;
      col_idx_r    <= '0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      err_mask_r   <= '0;
      tx_drop_r    <= 1'b0;
    end else begin
      code_r       <= code_s;
      mem_r        <= mem_s;
      col_r        <= col_s;
      col_valid_r  <= col_valid_s;
      col_idx_r    <= col_idx_s;
      busy_r       <= busy_s;
      frame_done_r <= frame_done_s;
      err_mask_r   <= err_mask_s;
      tx_drop_r    <= tx_drop_s;
    end
  end

  assign col_if.col       = col_r;
  assign col_if.col_valid = col_valid_r;
  assign col_if.col_idx   = col_idx_r;
  assign busy             = busy_r;
  assign frame_done       = frame_done_r;
  assign err_mask         = err_mask_r;
  assign tx_drop          = tx_drop_r;

endmodule
